// File: rtl/la_multichannel_readback_if.sv
// la_multichannel_readback_if: pod pointer, DRAM request/return and host stream signals of the readback engine
interface la_multichannel_readback_if #(
  parameter int ROW_BITS = 22
);
  logic flush_done;
  logic [ROW_BITS:0] read_rows;
  logic ptr_rd_en;
  logic [3:0] ptr_rd_addr;
  logic [28:0] ptr_rd_data;
  logic ram_addr_rd_en;
  logic [28:0] ram_addr_rd_data;
  logic [7:0] ram_addr_rd_size;
  logic ram_rd_data_start;
  logic ram_rd_data_valid;
  logic [127:0] ram_rd_data;
  logic out_valid;
  logic [127:0] out_data;
  logic [3:0] out_channel;
  logic out_first;
  logic out_last;
  logic busy;
  logic done;
  logic rsp_error;
  modport master (
    input flush_done, read_rows, ptr_rd_data, ram_addr_rd_en, ram_rd_data_start, ram_rd_data_valid, ram_rd_data,
    output ptr_rd_en, ptr_rd_addr, ram_addr_rd_data, ram_addr_rd_size, out_valid, out_data, out_channel,
    output out_first, out_last, busy, done, rsp_error
  );
  modport slave (
    output flush_done, read_rows, ptr_rd_data, ram_addr_rd_en, ram_rd_data_start, ram_rd_data_valid, ram_rd_data,
    input ptr_rd_en, ptr_rd_addr, ram_addr_rd_data, ram_addr_rd_size, out_valid, out_data, out_channel,
    input out_first, out_last, busy, done, rsp_error
  );
endinterface

// File: rtl/la_multichannel_readback.sv
// la_multichannel_readback: walks each channel ring oldest-first, queues DRAM row reads and tags returned beats
module la_multichannel_readback #(
  parameter int NUM_CHANNELS = 8,
  parameter int ROW_BITS = 22,
  parameter int BURST_BEATS = 1,
  parameter int MAX_OUTSTANDING = 16
) (
  input logic clk_ram_2x,
  input logic rst,
  la_multichannel_readback_if.master bus
);
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int LW = ROW_BITS + 2;
  localparam int BW = ROW_BITS + 2 + $clog2(BURST_BEATS);
  localparam int RW = $clog2(BURST_BEATS) + 1;
  localparam logic [7:0] MAX_O = 8'(MAX_OUTSTANDING);
  localparam logic [3:0] LAST_CH = 4'(NUM_CHANNELS - 1);
  localparam logic [ROW_BITS:0] ONE_ROW = (ROW_BITS + 1)'(1);
  localparam logic [LW-1:0] ROW_STEP = LW'(4);
  localparam logic [LW-1:0] ROW_MASK = ~LW'(3);
  typedef enum logic [2:0] {IDLE, PTR_REQ, PTR_WAIT, ISSUE, DRAIN} state_t;
  state_t state, state_n;
  logic [3:0] ch, rch;
  logic [28:0] addr;
  logic [28:0] mem [MAX_OUTSTANDING];
  logic [AW-1:0] wp, rp;
  logic [7:0] count, outstanding;
  logic [ROW_BITS:0] rows_cfg, rows_left;
  logic [BW-1:0] rbeat, last_beat;
  logic [RW-1:0] burst_rem;
  logic start, push, pop, bad, acc, dec, drained, done_n, is_last;
  assign start = bus.flush_done && bus.read_rows != '0;
  assign pop = bus.ram_addr_rd_en && count != 8'd0;
  assign drained = outstanding == 8'd0 && burst_rem == '0;
  assign bad = bus.ram_rd_data_valid && drained;
  assign acc = bus.ram_rd_data_valid && !bad;
  assign dec = acc && bus.ram_rd_data_start && outstanding != 8'd0;
  assign last_beat = BW'(rows_cfg) * BW'(BURST_BEATS) - BW'(1);
  assign is_last = rbeat == last_beat;
  assign bus.ptr_rd_en = state == PTR_REQ;
  assign bus.ptr_rd_addr = bus.ptr_rd_en ? ch : '0;
  assign bus.busy = state != IDLE;
  assign bus.ram_addr_rd_data = count != 8'd0 ? mem[rp] : '0;
  assign bus.ram_addr_rd_size = count;
  always_comb begin
    state_n = state;
    push = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = start ? PTR_REQ : IDLE;
        done_n = bus.flush_done && bus.read_rows == '0;
      end
      PTR_REQ: state_n = PTR_WAIT;
      PTR_WAIT: state_n = ISSUE;
      ISSUE: begin
        push = outstanding < MAX_O;
        if (push && rows_left == ONE_ROW) state_n = ch == LAST_CH ? DRAIN : PTR_REQ;
      end
      DRAIN: begin
        done_n = drained;
        state_n = drained ? IDLE : DRAIN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_ram_2x or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_ram_2x or posedge rst)
    if (rst) begin
      ch <= '0;
      addr <= '0;
      rows_cfg <= '0;
      rows_left <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= done_n;
      if (state == IDLE && start) begin
        rows_cfg <= bus.read_rows;
        ch <= '0;
      end
      if (state == PTR_WAIT) begin
        addr <= {bus.ptr_rd_data[28:LW], (bus.ptr_rd_data[LW-1:0] & ROW_MASK) - {rows_cfg[ROW_BITS-1:0], 2'b00}};
        rows_left <= rows_cfg;
      end
      if (push) begin
        addr <= {addr[28:LW], addr[LW-1:0] + ROW_STEP};
        rows_left <= rows_left - ONE_ROW;
        ch <= rows_left == ONE_ROW ? ch + 4'd1 : ch;
      end
    end
  always_ff @(posedge clk_ram_2x)
    if (push) mem[wp] <= addr;
  always_ff @(posedge clk_ram_2x or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      outstanding <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + 8'(push) - 8'(pop);
      outstanding <= outstanding + 8'(push) - 8'(dec);
    end
  always_ff @(posedge clk_ram_2x or posedge rst)
    if (rst) begin
      rch <= '0;
      rbeat <= '0;
      burst_rem <= '0;
      bus.rsp_error <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_channel <= '0;
      bus.out_first <= 1'b0;
      bus.out_last <= 1'b0;
    end else begin
      bus.out_valid <= acc;
      bus.rsp_error <= bus.rsp_error | bad;
      if (acc) begin
        bus.out_data <= bus.ram_rd_data;
        bus.out_channel <= rch;
        bus.out_first <= rbeat == '0;
        bus.out_last <= is_last;
        rbeat <= is_last ? '0 : rbeat + BW'(1);
        rch <= is_last ? rch + 4'd1 : rch;
      end
      if (dec) burst_rem <= RW'(BURST_BEATS - 1);
      else if (acc && burst_rem != '0) burst_rem <= burst_rem - RW'(1);
      if (state == IDLE && start) begin
        rch <= '0;
        rbeat <= '0;
      end
    end
endmodule
